// File: rtl/sd_dma_slave.sv
// sd_dma_slave: register-programmed DMA that requests 512-byte SD sectors and
// streams each sector's 128 words through a FIFO into a memory master.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   slv_*             : 4-word register slave (0 ADDR, 1 SECTOR, 2 COUNT, 3 CTRL/STATUS)
//   sd_cmd_*          : one-sector read command handshake
//   sd_data*, sd_error: SD word strobe (no backpressure) and error pulse
//   mem_*             : write-only memory master with waitrequest stall
//   irq               : completion / abort interrupt, only when SD_DMA_IRQ_EN is defined
//
// Optional feature macro: SD_DMA_IRQ_EN
module sd_dma_slave #(
    parameter int unsigned MEM_AW     = 28,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        slv_address,
    input  logic              slv_write,
    input  logic [31:0]       slv_writedata,
    input  logic              slv_read,
    output logic [31:0]       slv_readdata,
    output logic              slv_waitrequest,
    output logic              sd_cmd_valid,
    output logic [31:0]       sd_cmd_sector,
    input  logic              sd_cmd_ready,
    input  logic              sd_data_valid,
    input  logic [31:0]       sd_data,
    input  logic              sd_error,
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic              mem_waitrequest
`ifdef SD_DMA_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int unsigned PW           = $clog2(FIFO_DEPTH);
    localparam int unsigned SECTOR_WORDS = 128;
    localparam logic [PW:0] PTR_INC      = (PW+1)'(1);

    typedef enum logic [2:0] {IDLE, CMD, XFER, DRAIN, NEXT, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [MEM_AW-1:0] r_addr;
    logic [31:0]       r_sector;
    logic [15:0]       r_count;
    logic              r_done, r_error, r_overflow, r_abort;
    logic [6:0]        r_wcnt;
    logic [31:0]       r_fifo [FIFO_DEPTH];
    logic [PW:0]       r_wr_ptr, r_rd_ptr;
    logic              r_mem_write;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_be;
    logic              r_cmd_valid;
    logic              r_rd_pending;
    logic [31:0]       r_rdata;

    logic              w_busy, w_waitreq, w_wr_en, w_start;
    logic              w_empty, w_full, w_push, w_pop, w_mem_acc, w_sd_err;
    logic [31:0]       w_rd_mux;

    assign w_busy    = (r_state != IDLE);
    // First read cycle is the wait state; writes stall for the whole transfer.
    assign w_waitreq = (slv_read && !r_rd_pending) || (slv_write && w_busy);
    assign w_wr_en   = slv_write && !w_waitreq;
    assign w_start   = w_wr_en && (slv_address == 2'd3) && (slv_writedata == 32'd2);

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push    = (r_state == XFER) && sd_data_valid && !w_full;
    assign w_mem_acc = r_mem_write && !mem_waitrequest;
    // Load the next word whenever the output slot is free or being accepted.
    assign w_pop     = !w_empty && (!r_mem_write || !mem_waitrequest);
    assign w_sd_err  = sd_error &&
                       ((r_state == CMD) || (r_state == XFER) || (r_state == DRAIN));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_start) w_state_nxt = (r_count == 16'd0) ? DONE : CMD;
            CMD: begin
                if (sd_error)          w_state_nxt = DRAIN;
                else if (sd_cmd_ready) w_state_nxt = XFER;
            end
            XFER: begin
                if (sd_error || (sd_data_valid && r_wcnt == 7'(SECTOR_WORDS - 1)))
                    w_state_nxt = DRAIN;
            end
            // Leave only once the FIFO and the output slot are both empty.
            DRAIN: if (w_empty && !r_mem_write)
                       w_state_nxt = (r_abort || sd_error) ? IDLE : NEXT;
            NEXT:  w_state_nxt = ((r_count - 16'd1) != 16'd0) ? CMD : DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Register readback mux
    always_comb begin
        w_rd_mux = 32'd0;
        case (slv_address)
            2'd0: w_rd_mux = 32'(r_addr);
            2'd1: w_rd_mux = r_sector;
            2'd2: w_rd_mux = {16'd0, r_count};
            2'd3: w_rd_mux = {r_count, 12'd0, r_overflow, r_error, r_done, w_busy};
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Working registers, flags, FIFO pointers, memory master and slave read path
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_sector     <= '0;
            r_count      <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_overflow   <= 1'b0;
            r_abort      <= 1'b0;
            r_wcnt       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_mem_write  <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_cmd_valid  <= 1'b0;
            r_rd_pending <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_cmd_valid <= (w_state_nxt == CMD);

            if (w_wr_en) begin
                case (slv_address)
                    2'd0: r_addr   <= slv_writedata[MEM_AW-1:0];
                    2'd1: r_sector <= slv_writedata;
                    2'd2: r_count  <= slv_writedata[15:0];
                    default: ;
                endcase
            end
            if (w_start) begin
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_overflow <= 1'b0;
                r_abort    <= 1'b0;
            end

            if (w_mem_acc) r_addr <= r_addr + MEM_AW'(4);

            if (r_state == NEXT) begin
                r_sector <= r_sector + 32'd1;
                r_count  <= r_count - 16'd1;
            end
            if (r_state == DONE) r_done <= 1'b1;

            // Dropped words still count toward the sector length.
            if (r_state == CMD) r_wcnt <= '0;
            if ((r_state == XFER) && sd_data_valid) begin
                r_wcnt <= r_wcnt + 7'd1;
                if (w_full) begin
                    r_overflow <= 1'b1;
                    r_error    <= 1'b1;
                end
            end
            if (w_sd_err) begin
                r_error <= 1'b1;
                r_abort <= 1'b1;
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_INC;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PTR_INC;
                r_mem_write <= 1'b1;
                r_mem_wdata <= r_fifo[r_rd_ptr[PW-1:0]];
                r_mem_be    <= 4'hF;
            end else if (w_mem_acc) begin
                r_mem_write <= 1'b0;
            end

            if (slv_read && !r_rd_pending) begin
                r_rd_pending <= 1'b1;
                r_rdata      <= w_rd_mux;
            end else begin
                r_rd_pending <= 1'b0;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr[PW-1:0]] <= sd_data;
    end

`ifdef SD_DMA_IRQ_EN
    logic r_irq;
    // Set on completion or abort exit; set wins over a same-cycle STATUS read.
    always_ff @(posedge clk) begin
        if (rst)
            r_irq <= 1'b0;
        else if ((r_state == DONE) || ((r_state == DRAIN) && (w_state_nxt == IDLE) && (r_abort || sd_error)))
            r_irq <= 1'b1;
        else if (slv_read && r_rd_pending && (slv_address == 2'd3))
            r_irq <= 1'b0;
    end
    assign irq = r_irq;
`endif

    assign slv_readdata    = r_rdata;
    assign slv_waitrequest = w_waitreq;
    assign sd_cmd_valid    = r_cmd_valid;
    assign sd_cmd_sector   = r_sector;
    assign mem_address     = r_addr;
    assign mem_write       = r_mem_write;
    assign mem_writedata   = r_mem_wdata;
    assign mem_byteenable  = r_mem_be;

endmodule

// File: tb/tb_sd_dma_slave.sv
// Self-checking bench for sd_dma_slave: register vector table plus directed
// transfer sequences against an SD responder and a stalling memory model.
module tb_sd_dma_slave;
    localparam int unsigned MEM_AW = 28;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        slv_address = '0;
    logic              slv_write = 1'b0;
    logic [31:0]       slv_writedata = '0;
    logic              slv_read = 1'b0;
    logic [31:0]       slv_readdata;
    logic              slv_waitrequest;
    logic              sd_cmd_valid;
    logic [31:0]       sd_cmd_sector;
    logic              sd_cmd_ready = 1'b0;
    logic              sd_data_valid = 1'b0;
    logic [31:0]       sd_data = '0;
    logic              sd_error = 1'b0;
    logic [MEM_AW-1:0] mem_address;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [3:0]        mem_byteenable;
    logic              mem_waitrequest = 1'b0;
`ifdef SD_DMA_IRQ_EN
    logic              irq;
`endif

    sd_dma_slave #(.MEM_AW(MEM_AW), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .slv_address(slv_address), .slv_write(slv_write), .slv_writedata(slv_writedata),
        .slv_read(slv_read), .slv_readdata(slv_readdata), .slv_waitrequest(slv_waitrequest),
        .sd_cmd_valid(sd_cmd_valid), .sd_cmd_sector(sd_cmd_sector), .sd_cmd_ready(sd_cmd_ready),
        .sd_data_valid(sd_data_valid), .sd_data(sd_data), .sd_error(sd_error),
        .mem_address(mem_address), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest)
`ifdef SD_DMA_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Environment state shared between the main sequence and the models
    logic [31:0]       cmd_q[$];
    logic [31:0]       exp_q[$];
    int                words_sent = 0;
    int                mem_wr_cnt = 0;
    int                data_errs  = 0;
    int                addr_errs  = 0;
    logic [MEM_AW-1:0] exp_addr   = '0;
    logic [MEM_AW-1:0] last_addr  = '0;
    int                mem_stall  = 0;
    int                sd_gap     = 0;
    bit                sb_en      = 1'b0;
    bit                err_en     = 1'b0;
    int                err_cmd    = 0;
    int                err_word   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // SD card: accept each command, then stream 128 words of {sector[15:0], index}
    initial begin : sd_responder
        logic [31:0] sec;
        logic [31:0] w;
        int          idx;
        bit          hit;
        forever begin
            @(negedge clk);
            if (sd_cmd_valid && !rst) begin
                idx = cmd_q.size();
                sec = sd_cmd_sector;
                cmd_q.push_back(sec);
                sd_cmd_ready = 1'b1;
                @(negedge clk);
                sd_cmd_ready = 1'b0;
                for (int i = 0; i < 128; i++) begin
                    w   = {sec[15:0], 16'(i)};
                    hit = err_en && (idx == err_cmd) && (i == err_word);
                    sd_data_valid = 1'b1;
                    sd_data       = w;
                    sd_error      = hit;
                    if (sb_en) exp_q.push_back(w);
                    words_sent++;
                    @(negedge clk);
                    sd_data_valid = 1'b0;
                    sd_error      = 1'b0;
                    repeat (sd_gap) @(negedge clk);
                    if (hit) break;
                end
            end
        end
    end

    // Memory: stall each write mem_stall cycles, then log and score the accepted beat
    initial begin : mem_model
        int          stall_cnt;
        logic [31:0] w;
        stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_write && !rst) begin
                if (stall_cnt < mem_stall) begin
                    mem_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mem_waitrequest = 1'b0;
                    stall_cnt = 0;
                    mem_wr_cnt++;
                    if (mem_address !== exp_addr || mem_byteenable !== 4'hF) addr_errs++;
                    last_addr = mem_address;
                    exp_addr  = exp_addr + MEM_AW'(4);
                    if (sb_en) begin
                        if (exp_q.size() == 0) data_errs++;
                        else begin
                            w = exp_q.pop_front();
                            if (w !== mem_writedata) data_errs++;
                        end
                    end
                end
            end else begin
                mem_waitrequest = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        slv_address = a; slv_writedata = d; slv_write = 1'b1;
        #1;
        while (slv_waitrequest && waits < 5000) begin
            @(negedge clk); #1;
            waits++;
        end
        @(posedge clk); #1;
        slv_write = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d,
                            output logic ws1, output logic ws2);
        @(negedge clk);
        slv_address = a; slv_read = 1'b1;
        #1 ws1 = slv_waitrequest;
        @(posedge clk); #1;
        ws2 = slv_waitrequest;
        d   = slv_readdata;
        @(posedge clk); #1;
        slv_read = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        logic w1, w2;
        reg_read(a, d, w1, w2);
    endtask

    task automatic start_xfer(input logic [31:0] addr, input logic [31:0] sec, input logic [31:0] cnt);
        int w;
        exp_addr = addr[MEM_AW-1:0];
        exp_q.delete();
        reg_write(2'd0, addr, w);
        reg_write(2'd1, sec, w);
        reg_write(2'd2, cnt, w);
        reg_write(2'd3, 32'd2, w);
    endtask

    task automatic wait_idle(input int budget, output logic [31:0] st, output bit to);
        int n;
        n = 0;
        do begin
            rd(2'd3, st);
            n += 3;
        end while (st[0] && n < budget);
        to = st[0];
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_cmd_valid"},  64'(sd_cmd_valid), 64'd0);
        check({tag, "_mem_write"},  64'(mem_write), 64'd0);
        check({tag, "_mem_address"}, 64'(mem_address), 64'd0);
        check({tag, "_mem_wdata"},  64'(mem_writedata), 64'd0);
        check({tag, "_mem_be"},     64'(mem_byteenable), 64'd0);
        check({tag, "_readdata"},   64'(slv_readdata), 64'd0);
        check({tag, "_waitreq"},    64'(slv_waitrequest), 64'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    initial begin : main
        vec_t        vecs[15];
        logic [31:0] d;
        logic        ws1, ws2;
        int          waits, wr0, c0, n, seq_errs;
        bit          to;

        vecs[0]  = '{1'b0, 2'd0, 32'h0,          32'h0};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,          32'h0};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,          32'h0};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,          32'h0};
        vecs[4]  = '{1'b1, 2'd0, 32'h1234_5678,  32'h0};
        vecs[5]  = '{1'b0, 2'd0, 32'h0,          32'h0234_5678};
        vecs[6]  = '{1'b1, 2'd1, 32'hDEAD_BEEF,  32'h0};
        vecs[7]  = '{1'b0, 2'd1, 32'h0,          32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 2'd2, 32'hABCD_0005,  32'h0};
        vecs[9]  = '{1'b0, 2'd2, 32'h0,          32'h0000_0005};
        vecs[10] = '{1'b0, 2'd3, 32'h0,          32'h0005_0000};
        vecs[11] = '{1'b1, 2'd3, 32'h5,          32'h0};
        vecs[12] = '{1'b0, 2'd3, 32'h0,          32'h0005_0000};
        vecs[13] = '{1'b1, 2'd3, 32'h3,          32'h0};
        vecs[14] = '{1'b0, 2'd3, 32'h0,          32'h0005_0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle_outs("reset");
        rst = 1'b0;

        // Read wait-state timing
        reg_read(2'd3, d, ws1, ws2);
        check("rd_ws_first", 64'(ws1), 64'd1);
        check("rd_ws_second", 64'(ws2), 64'd0);

        // Register vector table
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) reg_write(vecs[i].a, vecs[i].d, waits);
            else begin
                rd(vecs[i].a, d);
                check($sformatf("vec%0d", i), 64'(d), 64'(vecs[i].exp));
            end
        end

        // COUNT=0: straight to DONE, no command, no memory write
        wr0 = mem_wr_cnt; c0 = cmd_q.size();
        reg_write(2'd2, 32'd0, waits);
        reg_write(2'd3, 32'd2, waits);
        @(negedge clk);
        rd(2'd3, d);
        check("cnt0_status", 64'(d), 64'h2);
        repeat (10) @(negedge clk);
        check("cnt0_no_cmd", 64'(cmd_q.size() - c0), 64'd0);
        check("cnt0_no_mem", 64'(mem_wr_cnt - wr0), 64'd0);

        // 128 sectors from 72 into 0x80F0000
        sb_en = 1'b1; mem_stall = 0; sd_gap = 0;
        wr0 = mem_wr_cnt; c0 = cmd_q.size();
        start_xfer(32'h080F_0000, 32'd72, 32'd128);
        wait_idle(40000, d, to);
        check("big_timeout", 64'(to), 64'd0);
        check("big_status", 64'(d), 64'h2);
        check("big_ncmd", 64'(cmd_q.size() - c0), 64'd128);
        check("big_first_sec", 64'(cmd_q[c0]), 64'd72);
        check("big_last_sec", 64'(cmd_q[cmd_q.size()-1]), 64'd199);
        seq_errs = 0;
        for (int i = c0; i < cmd_q.size(); i++)
            if (cmd_q[i] !== 32'(72 + i - c0)) seq_errs++;
        check("big_sec_seq", 64'(seq_errs), 64'd0);
        check("big_nwrites", 64'(mem_wr_cnt - wr0), 64'd16384);
        check("big_last_addr", 64'(last_addr), 64'h080F_FFFC);
        check("big_data", 64'(data_errs), 64'd0);
        rd(2'd0, d);
        check("big_addr_end", 64'(d), 64'h0810_0000);
        rd(2'd1, d);
        check("big_sector_end", 64'(d), 64'd200);

        // 3-cycle memory stall, SD paced slower than memory: no loss
        mem_stall = 3; sd_gap = 4;
        wr0 = mem_wr_cnt;
        start_xfer(32'h0000_1000, 32'd7, 32'd1);
        wait_idle(5000, d, to);
        check("slow_timeout", 64'(to), 64'd0);
        check("slow_status", 64'(d), 64'h2);
        check("slow_nwrites", 64'(mem_wr_cnt - wr0), 64'd128);
        check("slow_data", 64'(data_errs), 64'd0);

        // 3-cycle memory stall, SD back-to-back: FIFO overflows, transfer still completes
        sb_en = 1'b0; sd_gap = 0;
        start_xfer(32'h0000_2000, 32'd8, 32'd1);
        wait_idle(5000, d, to);
        check("ovf_timeout", 64'(to), 64'd0);
        check("ovf_status", 64'(d), 64'hE);
        repeat (5) @(negedge clk);
        mem_stall = 0;

        // ADDR write while busy stalls until IDLE, then lands
        sb_en = 1'b1;
        wr0 = mem_wr_cnt;
        start_xfer(32'h0020_0000, 32'd500, 32'd1);
        reg_write(2'd0, 32'h0ABC_DEF0, waits);
        check("busywr_stalled", 64'(waits > 0), 64'd1);
        check("busywr_no_timeout", 64'(waits < 5000), 64'd1);
        rd(2'd3, d);
        check("busywr_status", 64'(d), 64'h2);
        rd(2'd0, d);
        check("busywr_addr", 64'(d), 64'h0ABC_DEF0);
        check("busywr_nwrites", 64'(mem_wr_cnt - wr0), 64'd128);

        // sd_error on word 50 of sector 2 of 4, coincident with that word
        wr0 = mem_wr_cnt; c0 = cmd_q.size();
        err_en = 1'b1; err_cmd = c0 + 1; err_word = 49;
        start_xfer(32'h0000_0100, 32'd10, 32'd4);
        wait_idle(5000, d, to);
        err_en = 1'b0;
        check("err_timeout", 64'(to), 64'd0);
        check("err_status", 64'(d), 64'h0003_0004);
        check("err_ncmd", 64'(cmd_q.size() - c0), 64'd2);
        check("err_nwrites", 64'(mem_wr_cnt - wr0), 64'd178);
        check("err_data", 64'(data_errs), 64'd0);
        rd(2'd1, d);
        check("err_sector", 64'(d), 64'd11);

        // Reset in the middle of XFER with a memory write pending
        sb_en = 1'b0; mem_stall = 3;
        start_xfer(32'h0000_0300, 32'd900, 32'd2);
        n = 0;
        while (words_sent < 0 + words_sent && n < 0) n++;
        c0 = words_sent;
        n = 0;
        while ((words_sent - c0) < 40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_timeout", 64'(n < 2000), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outs("midrst");
        #1 rst = 1'b0;
        wr0 = mem_wr_cnt; c0 = cmd_q.size();
        repeat (300) @(negedge clk);
        check("midrst_no_writes", 64'(mem_wr_cnt - wr0), 64'd0);
        check("midrst_no_cmd", 64'(cmd_q.size() - c0), 64'd0);
        rd(2'd3, d);
        check("midrst_status", 64'(d), 64'h0);
        rd(2'd0, d);
        check("midrst_addr", 64'(d), 64'h0);

        check("addr_be_all", 64'(addr_errs), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sd_dma_slave.md
SD_DMA_SLAVE -- requirements
Module: sd_dma_slave

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-002 Parameter MEM_AW, default 28, SHALL set the memory master address width.
REQ-003 Parameter FIFO_DEPTH, default 16 (power of two, minimum 4), SHALL set the sector-data buffer depth in words.
REQ-004 Register slave ports SHALL be:
- slv_address, in, 2: word index (0 ADDR, 1 SECTOR, 2 COUNT, 3 CTRL/STATUS)
- slv_write, in, 1
- slv_writedata, in, 32
- slv_read, in, 1
- slv_readdata, out, 32
- slv_waitrequest, out, 1
REQ-005 SD command ports SHALL be:
- sd_cmd_valid, out, 1: request one 512-byte sector
- sd_cmd_sector, out, 32: sector number
- sd_cmd_ready, in, 1: command accepted
REQ-006 SD data ports SHALL be:
- sd_data_valid, in, 1: one word strobe, no backpressure
- sd_data, in, 32
- sd_error, in, 1: one-cycle error pulse
REQ-007 Memory master ports SHALL be:
- mem_address, out, MEM_AW
- mem_write, out, 1
- mem_writedata, out, 32
- mem_byteenable, out, 4
- mem_waitrequest, in, 1

Function
REQ-008 Register writes SHALL complete in the cycle slv_write=1 and slv_waitrequest=0; ADDR, SECTOR and COUNT SHALL be loaded with slv_writedata, and COUNT SHALL keep only bits [15:0].
REQ-009 While busy, slv_waitrequest SHALL be held high for every write until the block returns to IDLE; the write SHALL then complete.
REQ-010 Reads SHALL take one wait state: waitrequest=1 in the first cycle, then waitrequest=0 with registered slv_readdata in the second; reads SHALL NOT stall while busy.
REQ-011 STATUS read SHALL return: bit0 busy, bit1 done, bit2 error, bit3 overflow, [31:16] sectors remaining; reading ADDR, SECTOR or COUNT SHALL return the live working values.
REQ-012 A CTRL write of value 2 in IDLE SHALL clear done, error and overflow and enter CMD the next cycle; any other CTRL value SHALL be ignored.
REQ-013 The FSM SHALL have the states IDLE, CMD, XFER, DRAIN, NEXT and DONE.
REQ-014 CMD: the block SHALL assert sd_cmd_valid with sd_cmd_sector=SECTOR, held until sd_cmd_ready, then go to XFER.
REQ-015 XFER: each sd_data_valid SHALL push one word into the FIFO; after 128 words the block SHALL go to DRAIN.
REQ-016 The memory side SHALL pop the FIFO head to mem_writedata with mem_byteenable=4'hF and hold mem_write, address and data stable while mem_waitrequest=1.
REQ-017 On each accepted memory write, ADDR SHALL increment by 4, wrapping modulo 2^MEM_AW.
REQ-018 DRAIN: when the FIFO is empty and no memory write is pending, the block SHALL go to NEXT.
REQ-019 NEXT: SECTOR SHALL be incremented and COUNT decremented; the block SHALL go to CMD if the new COUNT is nonzero, otherwise to DONE.
REQ-020 DONE SHALL set done=1 and return to IDLE in one cycle.
REQ-021 A CTRL=2 write with COUNT=0 SHALL go directly to DONE with no SD command and no memory write.
REQ-022 sd_data_valid arriving while the FIFO is full SHALL drop the word, set overflow and error, and the transfer SHALL continue counting.
REQ-023 sd_data_valid arriving outside XFER SHALL be ignored.
REQ-024 sd_error in CMD, XFER or DRAIN SHALL set error and force DRAIN, then IDLE with COUNT unchanged and done=0.
REQ-025 If sd_error and sd_data_valid occur in the same cycle, the word SHALL be accepted before the abort.

Reset
REQ-026 On rst=1 at a clock edge the block SHALL reset ADDR, SECTOR, COUNT, all flags, the FIFO pointers and the FSM (IDLE).
REQ-027 After that reset edge, sd_cmd_valid, mem_write, mem_address, mem_writedata, mem_byteenable and slv_readdata SHALL be 0 and slv_waitrequest SHALL be 0.
REQ-028 Reset mid-transfer SHALL abort without completing the pending memory write; SD data still arriving afterwards SHALL be ignored per REQ-023.

Configuration
REQ-029 With SD_DMA_IRQ_EN defined, an output irq (1 bit, reset 0) SHALL be set on entry to DONE or on the error abort, and cleared by a STATUS read.
REQ-030 Without SD_DMA_IRQ_EN, the irq port and its logic SHALL be absent.

Verification
REQ-031 ADDR=0x80F0000, SECTOR=72, COUNT=128, CTRL=2 -> 128 commands on sectors 72..199; 16384 memory writes from 0x80F0000 up to 0x80FFFFC; STATUS=0x2.
REQ-032 A memory stall of 3 cycles on every write while SD streams back-to-back -> no data loss if FIFO never full; otherwise overflow=1 and STATUS bit2=1.
REQ-033 COUNT=0, CTRL=2 -> DONE within 2 cycles; sd_cmd_valid and mem_write never asserted.
REQ-034 ADDR write during busy -> slv_waitrequest stays high until IDLE, then ADDR equals the written value.
REQ-035 sd_error after 50 words of sector 2 of 4 -> DRAIN, then IDLE; STATUS error=1, done=0, remaining=3.
REQ-036 rst pulse mid-XFER -> the next cycle shows all outputs 0 and state IDLE; later sd_data_valid words are not written to memory.
